// File: rtl/pixel_arb_pkg.sv
// rtl/pixel_arb_pkg.sv - shared types and default widths for the pixel write arbiter
package pixel_arb_pkg;

  localparam int NUM_REQ_DEF       = 2;
  localparam int ADDR_WIDTH_DEF    = 15;
  localparam int FB_DATA_WIDTH_DEF = 4;
  localparam int DB_DATA_WIDTH_DEF = 12;
  localparam int HAZARD_DEPTH_DEF  = 3;
  localparam int HIST_ADDR_W       = 32;

  typedef enum logic [2:0] {
    WAIT_READY,
    RUN,
    DRAIN,
    CLEAR,
    CLEAR_WAIT
  } arb_state_e;

  // Addresses are held zero-extended so the entry type is independent of ADDR_WIDTH (<= 32).
  typedef struct packed {
    logic                   valid;
    logic [HIST_ADDR_W-1:0] addr;
  } hist_entry_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pixel_write_arbiter_rr_arbiter.sv
// rtl/pixel_write_arbiter_rr_arbiter.sv - combinational masked round-robin selector
module rr_arbiter
  import pixel_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = idx_width(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          grant_valid
);

  logic [N-1:0] masked;

  always_comb begin
    masked = '0;
    for (int i = 0; i < N; i++) begin
      masked[i] = eligible[i] && (i >= int'(ptr));
    end
  end

  // Lowest eligible index at or above the pointer, else wrap to the lowest eligible index.
  always_comb begin
    grant_idx = '0;
    if (|masked) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (masked[i]) grant_idx = PW'(i);
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (eligible[i]) grant_idx = PW'(i);
      end
    end
    grant_valid = |eligible;
    grant       = grant_valid ? (N'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/pixel_write_arbiter.sv
// rtl/pixel_write_arbiter.sv - shares the display pixel write port; PIXEL_ARB_STATS_EN adds stall/grant counters
module pixel_write_arbiter
  import pixel_arb_pkg::*;
#(
  parameter int NUM_REQ       = NUM_REQ_DEF,
  parameter int ADDR_WIDTH    = ADDR_WIDTH_DEF,
  parameter int FB_DATA_WIDTH = FB_DATA_WIDTH_DEF,
  parameter int DB_DATA_WIDTH = DB_DATA_WIDTH_DEF,
  parameter int HAZARD_DEPTH  = HAZARD_DEPTH_DEF
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_REQ-1:0]                     req_valid,
  output logic [NUM_REQ-1:0]                     req_ready,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]     req_addr,
  input  logic [NUM_REQ-1:0][FB_DATA_WIDTH-1:0]  req_fb_data,
  input  logic [NUM_REQ-1:0][DB_DATA_WIDTH-1:0]  req_db_data,
  input  logic                                   clear_req,
  input  logic                                   display_ready,
  output logic [ADDR_WIDTH-1:0]                  o_addr,
  output logic [FB_DATA_WIDTH-1:0]               o_fb_data,
  output logic [DB_DATA_WIDTH-1:0]               o_db_data,
  output logic                                   o_inside,
  output logic                                   o_clear,
  output logic                                   clear_busy
`ifdef PIXEL_ARB_STATS_EN
  ,
  output logic [31:0]                            stat_hazard_stalls,
  output logic [31:0]                            stat_grants
`endif
);

  localparam int PW = idx_width(NUM_REQ);
  localparam int CW = idx_width(HAZARD_DEPTH + 1);
  // This cycle's grant is the newest slot of the hazard window, so only
  // HAZARD_DEPTH-1 older grants are flopped (HAZARD_DEPTH >= 2).
  localparam int HL = HAZARD_DEPTH - 1;

  arb_state_e                state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [PW-1:0]             ptr_q, ptr_d;
  hist_entry_t               hist_q [HL];
  hist_entry_t               hist_d [HL];
  logic [ADDR_WIDTH-1:0]     o_addr_q, o_addr_d;
  logic [FB_DATA_WIDTH-1:0]  o_fb_data_q, o_fb_data_d;
  logic [DB_DATA_WIDTH-1:0]  o_db_data_q, o_db_data_d;
  logic                      o_inside_q, o_inside_d;

  logic [NUM_REQ-1:0]        hazard_ok;
  logic [NUM_REQ-1:0]        eligible;
  logic [NUM_REQ-1:0]        arb_grant;
  logic [PW-1:0]             arb_idx;
  logic                      arb_valid;
  logic                      grant_en;

  always_comb begin
    hazard_ok = '1;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int k = 0; k < HL; k++) begin
        if (hist_q[k].valid && (hist_q[k].addr == HIST_ADDR_W'(req_addr[i]))) begin
          hazard_ok[i] = 1'b0;
        end
      end
    end
  end

  // A clear request takes the cycle: nobody is granted alongside it.
  assign grant_en = (state_q == RUN) && !clear_req;
  assign eligible = req_valid & hazard_ok & {NUM_REQ{grant_en}};

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_rr_arbiter (
    .eligible    (eligible),
    .ptr         (ptr_q),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  assign req_ready = arb_grant;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      WAIT_READY: begin
        if (display_ready) state_d = RUN;
      end
      RUN: begin
        if (clear_req) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        if (cnt_q == CW'(HAZARD_DEPTH - 1)) state_d = CLEAR;
        else cnt_d = cnt_q + 1'b1;
      end
      CLEAR: begin
        state_d = CLEAR_WAIT;
        cnt_d   = '0;
      end
      CLEAR_WAIT: begin
        if (cnt_q == '0) cnt_d = CW'(1);
        else if (display_ready) state_d = RUN;
      end
      default: state_d = WAIT_READY;
    endcase
  end

  always_comb begin
    ptr_d       = ptr_q;
    o_addr_d    = o_addr_q;
    o_fb_data_d = o_fb_data_q;
    o_db_data_d = o_db_data_q;
    o_inside_d  = arb_valid;
    hist_d[0].valid = arb_valid;
    hist_d[0].addr  = HIST_ADDR_W'(req_addr[arb_idx]);
    for (int k = 1; k < HL; k++) begin
      hist_d[k] = hist_q[k-1];
    end
    if (arb_valid) begin
      o_addr_d    = req_addr[arb_idx];
      o_fb_data_d = req_fb_data[arb_idx];
      o_db_data_d = req_db_data[arb_idx];
      ptr_d       = (arb_idx == PW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT_READY;
      cnt_q       <= '0;
      ptr_q       <= '0;
      o_addr_q    <= '0;
      o_fb_data_q <= '0;
      o_db_data_q <= '0;
      o_inside_q  <= 1'b0;
      for (int k = 0; k < HL; k++) hist_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      o_addr_q    <= o_addr_d;
      o_fb_data_q <= o_fb_data_d;
      o_db_data_q <= o_db_data_d;
      o_inside_q  <= o_inside_d;
      for (int k = 0; k < HL; k++) hist_q[k] <= hist_d[k];
    end
  end

  assign o_addr     = o_addr_q;
  assign o_fb_data  = o_fb_data_q;
  assign o_db_data  = o_db_data_q;
  assign o_inside   = o_inside_q;
  assign o_clear    = (state_q == CLEAR);
  assign clear_busy = (state_q != RUN);

`ifdef PIXEL_ARB_STATS_EN
  logic [31:0] stalls_q, stalls_d;
  logic [31:0] grants_q, grants_d;

  always_comb begin
    stalls_d = stalls_q;
    grants_d = grants_q;
    if (o_clear) begin
      stalls_d = '0;
      grants_d = '0;
    end else begin
      if ((state_q == RUN) && (|req_valid) && !(|(req_valid & hazard_ok)) && (stalls_q != '1)) begin
        stalls_d = stalls_q + 32'd1;
      end
      if (arb_valid && (grants_q != '1)) grants_d = grants_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stalls_q <= '0;
      grants_q <= '0;
    end else begin
      stalls_q <= stalls_d;
      grants_q <= grants_d;
    end
  end

  assign stat_hazard_stalls = stalls_q;
  assign stat_grants        = grants_q;
`endif

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// tb/tb_pixel_write_arbiter.sv - table-driven bench for pixel_write_arbiter (2 requesters, HAZARD_DEPTH 3)
module tb_pixel_write_arbiter;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][14:0] req_addr;
  logic [1:0][3:0]  req_fb_data;
  logic [1:0][11:0] req_db_data;
  logic             clear_req;
  logic             display_ready;
  logic [14:0]      o_addr;
  logic [3:0]       o_fb_data;
  logic [11:0]      o_db_data;
  logic             o_inside;
  logic             o_clear;
  logic             clear_busy;
`ifdef PIXEL_ARB_STATS_EN
  logic [31:0]      stat_hazard_stalls;
  logic [31:0]      stat_grants;
`endif

  int n_cmp = 0;
  int n_err = 0;

  pixel_write_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_fb_data   (req_fb_data),
    .req_db_data   (req_db_data),
    .clear_req     (clear_req),
    .display_ready (display_ready),
    .o_addr        (o_addr),
    .o_fb_data     (o_fb_data),
    .o_db_data     (o_db_data),
    .o_inside      (o_inside),
    .o_clear       (o_clear),
    .clear_busy    (clear_busy)
`ifdef PIXEL_ARB_STATS_EN
    ,
    .stat_hazard_stalls (stat_hazard_stalls),
    .stat_grants        (stat_grants)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  v;
    logic [14:0] a0;
    logic [14:0] a1;
    logic        clr;
    logic        dr;
    logic [1:0]  e_rdy;
    logic        e_ins;
    logic [14:0] e_addr;
    int          e_src;
    logic        e_clr;
    logic        e_busy;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(input logic [1:0] v, input logic [14:0] a0, input logic [14:0] a1,
                              input logic clr, input logic dr, input logic [1:0] e_rdy,
                              input logic e_ins, input logic [14:0] e_addr, input int e_src,
                              input logic e_clr, input logic e_busy);
    vec_t t;
    t.v = v; t.a0 = a0; t.a1 = a1; t.clr = clr; t.dr = dr;
    t.e_rdy = e_rdy; t.e_ins = e_ins; t.e_addr = e_addr; t.e_src = e_src;
    t.e_clr = e_clr; t.e_busy = e_busy;
    return t;
  endfunction

  // Source 0 = reset value, 1 = requester 0 data, 2 = requester 1 data.
  function automatic logic [3:0] exp_fb(input int s);
    case (s)
      1:       return 4'hA;
      2:       return 4'h5;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [11:0] exp_db(input int s);
    case (s)
      1:       return 12'h0AA;
      2:       return 12'h155;
      default: return 12'h000;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " req_ready"},  32'(req_ready),  32'h0);
    check({tag, " o_addr"},     32'(o_addr),     32'h0);
    check({tag, " o_fb_data"},  32'(o_fb_data),  32'h0);
    check({tag, " o_db_data"},  32'(o_db_data),  32'h0);
    check({tag, " o_inside"},   32'(o_inside),   32'h0);
    check({tag, " o_clear"},    32'(o_clear),    32'h0);
    check({tag, " clear_busy"}, 32'(clear_busy), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int m;

    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(2'b11, 15'h0010, 15'h0020, 0, 0, 2'b00, 0, 15'h0000, 0, 0, 1));
    tbl.push_back(mk(2'b11, 15'h0010, 15'h0020, 0, 1, 2'b00, 0, 15'h0000, 0, 0, 1)); // r10
    tbl.push_back(mk(2'b11, 15'h0010, 15'h0020, 0, 1, 2'b01, 0, 15'h0000, 0, 0, 0)); // r11
    tbl.push_back(mk(2'b11, 15'h0030, 15'h0020, 0, 1, 2'b10, 1, 15'h0010, 1, 0, 0)); // r12
    tbl.push_back(mk(2'b11, 15'h0030, 15'h0040, 0, 1, 2'b01, 1, 15'h0020, 2, 0, 0)); // r13
    tbl.push_back(mk(2'b11, 15'h0050, 15'h0040, 0, 1, 2'b10, 1, 15'h0030, 1, 0, 0)); // r14
    tbl.push_back(mk(2'b00, 15'h0050, 15'h0060, 0, 1, 2'b00, 1, 15'h0040, 2, 0, 0)); // r15
    tbl.push_back(mk(2'b00, 15'h0050, 15'h0060, 0, 1, 2'b00, 0, 15'h0040, 2, 0, 0)); // r16
    tbl.push_back(mk(2'b01, 15'h1234, 15'h0060, 0, 1, 2'b01, 0, 15'h0040, 2, 0, 0)); // r17
    tbl.push_back(mk(2'b01, 15'h1234, 15'h0060, 0, 1, 2'b00, 1, 15'h1234, 1, 0, 0)); // r18
    tbl.push_back(mk(2'b01, 15'h1234, 15'h0060, 0, 1, 2'b00, 0, 15'h1234, 1, 0, 0)); // r19
    tbl.push_back(mk(2'b01, 15'h1234, 15'h0060, 0, 1, 2'b01, 0, 15'h1234, 1, 0, 0)); // r20
    tbl.push_back(mk(2'b00, 15'h1234, 15'h0060, 0, 1, 2'b00, 1, 15'h1234, 1, 0, 0)); // r21
    tbl.push_back(mk(2'b01, 15'h0100, 15'h0060, 0, 1, 2'b01, 0, 15'h1234, 1, 0, 0)); // r22
    tbl.push_back(mk(2'b10, 15'h0100, 15'h0300, 0, 1, 2'b10, 1, 15'h0100, 1, 0, 0)); // r23
    tbl.push_back(mk(2'b11, 15'h0100, 15'h0200, 0, 1, 2'b10, 1, 15'h0300, 2, 0, 0)); // r24
    tbl.push_back(mk(2'b11, 15'h0100, 15'h0400, 0, 1, 2'b01, 1, 15'h0200, 2, 0, 0)); // r25
    tbl.push_back(mk(2'b00, 15'h0100, 15'h0400, 0, 1, 2'b00, 1, 15'h0100, 1, 0, 0)); // r26
    tbl.push_back(mk(2'b01, 15'h0500, 15'h0400, 1, 1, 2'b00, 0, 15'h0100, 1, 0, 0)); // r27
    tbl.push_back(mk(2'b01, 15'h0500, 15'h0400, 1, 1, 2'b00, 0, 15'h0100, 1, 0, 1)); // r28
    tbl.push_back(mk(2'b01, 15'h0500, 15'h0400, 0, 1, 2'b00, 0, 15'h0100, 1, 0, 1)); // r29
    tbl.push_back(mk(2'b01, 15'h0500, 15'h0400, 0, 1, 2'b00, 0, 15'h0100, 1, 0, 1)); // r30
    tbl.push_back(mk(2'b01, 15'h0500, 15'h0400, 0, 0, 2'b00, 0, 15'h0100, 1, 1, 1)); // r31
    tbl.push_back(mk(2'b01, 15'h0500, 15'h0400, 0, 0, 2'b00, 0, 15'h0100, 1, 0, 1)); // r32
    tbl.push_back(mk(2'b01, 15'h0500, 15'h0400, 1, 0, 2'b00, 0, 15'h0100, 1, 0, 1)); // r33
    tbl.push_back(mk(2'b01, 15'h0500, 15'h0400, 0, 0, 2'b00, 0, 15'h0100, 1, 0, 1)); // r34
    tbl.push_back(mk(2'b01, 15'h0500, 15'h0400, 0, 1, 2'b00, 0, 15'h0100, 1, 0, 1)); // r35
    tbl.push_back(mk(2'b01, 15'h0500, 15'h0400, 0, 1, 2'b01, 0, 15'h0100, 1, 0, 0)); // r36
    tbl.push_back(mk(2'b00, 15'h0500, 15'h0400, 0, 1, 2'b00, 1, 15'h0500, 1, 0, 0)); // r37
    tbl.push_back(mk(2'b00, 15'h0500, 15'h0400, 0, 1, 2'b00, 0, 15'h0500, 1, 0, 0)); // r38

    rst_n = 1'b0;
    req_valid = '0;
    req_addr = '0;
    req_fb_data[0] = 4'hA;
    req_fb_data[1] = 4'h5;
    req_db_data[0] = 12'h0AA;
    req_db_data[1] = 12'h155;
    clear_req = 1'b0;
    display_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;

    for (int r = 0; r < tbl.size(); r++) begin
      @(negedge clk);
      req_valid     = tbl[r].v;
      req_addr[0]   = tbl[r].a0;
      req_addr[1]   = tbl[r].a1;
      clear_req     = tbl[r].clr;
      display_ready = tbl[r].dr;
      #1;
      check($sformatf("r%0d req_ready", r),  32'(req_ready),  32'(tbl[r].e_rdy));
      check($sformatf("r%0d o_inside", r),   32'(o_inside),   32'(tbl[r].e_ins));
      check($sformatf("r%0d o_addr", r),     32'(o_addr),     32'(tbl[r].e_addr));
      check($sformatf("r%0d o_fb_data", r),  32'(o_fb_data),  32'(exp_fb(tbl[r].e_src)));
      check($sformatf("r%0d o_db_data", r),  32'(o_db_data),  32'(exp_db(tbl[r].e_src)));
      check($sformatf("r%0d o_clear", r),    32'(o_clear),    32'(tbl[r].e_clr));
      check($sformatf("r%0d clear_busy", r), 32'(clear_busy), 32'(tbl[r].e_busy));
`ifdef PIXEL_ARB_STATS_EN
      if (r == 27) begin
        check("stat_hazard_stalls", stat_hazard_stalls, 32'd2);
        check("stat_grants", stat_grants, 32'd10);
      end
`endif
    end

    // Clear latency with display_ready held high: o_clear 4 cycles on, run resumes 3 after it.
    @(negedge clk);
    req_valid = 2'b00;
    clear_req = 1'b1;
    #1;
    n = 0;
    do begin
      @(negedge clk);
      clear_req = 1'b0;
      #1;
      n++;
    end while (!o_clear && n < 20);
    check("clear_pulse_latency", 32'(n), 32'd4);
    m = 0;
    while (clear_busy && m < 20) begin
      @(negedge clk);
      #1;
      m++;
    end
    check("resume_after_clear", 32'(m), 32'd3);

    // Reset while in CLEAR_WAIT with a non-zero write on the outputs.
    @(negedge clk);
    req_valid   = 2'b01;
    req_addr[0] = 15'h0777;
    #1;
    check("grant_0777", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = 2'b00;
    clear_req = 1'b1;
    #1;
    check("o_addr_0777", 32'(o_addr), 32'h0777);
    n = 0;
    do begin
      @(negedge clk);
      clear_req = 1'b0;
      #1;
      n++;
    end while (!o_clear && n < 20);
    check("second_clear_latency", 32'(n), 32'd4);
    @(negedge clk);
    #1;
    check("in_clear_wait", 32'(clear_busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_clear_reset");
    @(negedge clk);
    rst_n       = 1'b1;
    req_valid   = 2'b01;
    req_addr[0] = 15'h0777;
    #1;
    check("post_reset_wait_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    #1;
    check("post_reset_grant", 32'(req_ready), 32'h1);

    // Reset right after a grant: history must forget 0x0777 immediately.
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
    check("pulse_reset_busy", 32'(clear_busy), 32'h1);
    check("pulse_reset_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    #1;
    check("hist_cleared_regrant", 32'(req_ready), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
